// File: rtl/out_shift_reg_if.sv
// Word-source / link-side bus of the parallel-in serial-out transmitter.
// The master drives Load/In/SelKeep, and the slave (out_shift_reg) drives the stream.
interface out_shift_reg_if #(
  parameter int N1 = 102,
  parameter int N2 = 6
);
  logic                   Load;
  logic [N2-1:0][N1-1:0]  In;
  logic                   SelKeep;
  logic                   Ready;
  logic [N2-1:0]          Out;
  logic                   OutValid;
  logic                   Done;

  modport master (output Load, In, SelKeep, input Ready, Out, OutValid, Done);
  modport slave  (input Load, In, SelKeep, output Ready, Out, OutValid, Done);
endinterface

// File: rtl/out_shift_reg.sv
// N2-lane parallel-in, serial-out transmitter, MSB-first, with a Load/Ready/Done handshake and a SelKeep stall.
// Optional macro OUT_PARITY_EN appends one even-parity bit per lane after the data bits.
module out_shift_reg #(
  parameter int N1 = 102,
  parameter int N2 = 6
) (
  input  logic            Clock,
  input  logic            nReset,
  out_shift_reg_if.slave  bus
);

  localparam int             CW   = $clog2(N1 + 2);
  localparam logic [CW-1:0]  LAST = CW'(N1 - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef OUT_PARITY_EN
    SHIFT,
    PAR
`else
    SHIFT
`endif
  } state_t;

  state_t                 r_state;
  logic [N2-1:0][N1-1:0]  r_shift;
  logic [CW-1:0]          r_cnt;
  logic                   r_done;
  logic [N2-1:0]          w_out;
`ifdef OUT_PARITY_EN
  logic [N2-1:0]          r_par;
`endif

  // NOTE: Sequential state uses non-blocking assignments only. This way every register samples pre-edge values.
  // NOTE: The shift registers get an explicit reset, so Out is defined from the first cycle after nReset.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef OUT_PARITY_EN
      r_par   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Load) begin
            r_shift <= bus.In;
            r_cnt   <= '0;
            r_state <= SHIFT;
`ifdef OUT_PARITY_EN
            for (int k = 0; k < N2; k++) r_par[k] <= ^bus.In[k];
`endif
          end
        end
        SHIFT: begin
          if (!bus.SelKeep) begin
            for (int k = 0; k < N2; k++) r_shift[k] <= {r_shift[k][N1-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
`ifdef OUT_PARITY_EN
              r_state <= PAR;
`else
              r_state <= IDLE;
              r_done  <= 1'b1;
`endif
            end
          end
        end
`ifdef OUT_PARITY_EN
        PAR: begin
          if (!bus.SelKeep) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: Give w_out a default before the case. That way every path assigns it and no latch is inferred.
  always_comb begin
    w_out = '0;
    if (r_state == SHIFT) begin
      for (int k = 0; k < N2; k++) w_out[k] = r_shift[k][N1-1];
    end
`ifdef OUT_PARITY_EN
    else if (r_state == PAR) begin
      w_out = r_par;
    end
`endif
  end

  assign bus.Out      = w_out;
  assign bus.Ready    = (r_state == IDLE);
  assign bus.OutValid = (r_state != IDLE);
  assign bus.Done     = r_done;

endmodule

// File: tb/tb_out_shift_reg.sv
// Scoreboard bench for out_shift_reg. The driver pushes the expected serial stream and Done cycle for each frame.
// A negedge monitor pops these entries and compares them against the DUT.
module tb_out_shift_reg;

  localparam int N1 = 102;
  localparam int N2 = 6;
`ifdef OUT_PARITY_EN
  localparam int NB = N1 + 1;
`else
  localparam int NB = N1;
`endif

  typedef logic [N2-1:0][N1-1:0] lanes_t;

  logic Clock = 1'b0;
  logic nReset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [N2-1:0] exp_q[$];
  int            done_q[$];

  out_shift_reg_if #(.N1(N1), .N2(N2)) bus ();

  out_shift_reg #(.N1(N1), .N2(N2)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected lane vector for frame bit b: data MSB-first, then the even parity of each lane
  function automatic logic [N2-1:0] exp_bits(input lanes_t l, input int b);
    logic [N2-1:0] v;
    for (int k = 0; k < N2; k++) v[k] = (b < N1) ? l[k][N1-1-b] : ^l[k];
    return v;
  endfunction

  function automatic lanes_t rand_lanes();
    lanes_t l;
    for (int k = 0; k < N2; k++)
      for (int i = 0; i < N1; i++) l[k][i] = 1'($urandom_range(0, 1));
    return l;
  endfunction

  // Monitor: compares every cycle while out of reset
  always @(negedge Clock) begin
    if (nReset) begin
      if (bus.Done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        check("bits_left_at_done", 64'(exp_q.size()), 0);
      end
      if (bus.OutValid) begin
        if (exp_q.size() == 0) check("extra_valid_bit", 1, 0);
        else check("out_bits", 64'(bus.Out), 64'(exp_q.pop_front()));
      end else begin
        check("idle_out_zero", 64'(bus.Out), 0);
      end
      check("ready_vs_valid", 64'(bus.Ready), 64'(!bus.OutValid));
    end
  end

  task automatic idle(input int n);
    bus.Load = 1'b0;
    repeat (n) begin
      bus.SelKeep = 1'($urandom_range(0, 1));
      @(posedge Clock); #1;
    end
    bus.SelKeep = 1'b0;
  endtask

  // Call this task just after a posedge. It returns in the Done cycle, or after the reset released by an abort.
  task automatic send_frame(input lanes_t lanes, input int stall_at, input int stall_len,
                            input int ign_at, input bit keep_at_load, input int abort_at);
    int guard = 0;
    int stalled;
    int l_cyc;
    while (!bus.Ready && guard < 300) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (!bus.Ready) check("ready_timeout", 0, 1);
    bus.Load    = 1'b1;
    bus.In      = lanes;
    bus.SelKeep = keep_at_load;
    @(posedge Clock); #1;
    l_cyc       = cyc;
    bus.Load    = 1'b0;
    bus.In      = rand_lanes();
    bus.SelKeep = 1'b0;
    stalled = (stall_at >= 0 && stall_at < NB) ? stall_len : 0;
    for (int b = 0; b < NB; b++) begin
      if (b == stall_at) repeat (stall_len) exp_q.push_back(exp_bits(lanes, b));
      exp_q.push_back(exp_bits(lanes, b));
    end
    done_q.push_back(l_cyc + NB + stalled);
    for (int b = 0; b < NB; b++) begin
      if (b == abort_at) begin
        nReset = 1'b0;
        #1;
        check("abort_ready", 64'(bus.Ready), 1);
        check("abort_out", 64'(bus.Out), 0);
        check("abort_valid", 64'(bus.OutValid), 0);
        check("abort_done", 64'(bus.Done), 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;
        return;
      end
      if (b == stall_at) begin
        bus.SelKeep = 1'b1;
        repeat (stall_len) begin
          @(posedge Clock); #1;
        end
        bus.SelKeep = 1'b0;
      end
      if (b == ign_at) begin
        bus.Load = 1'b1;
        bus.In   = ~lanes;
      end
      @(posedge Clock); #1;
      bus.Load = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    lanes_t spec_l;
    nReset      = 1'b0;
    bus.Load    = 1'b0;
    bus.In      = '0;
    bus.SelKeep = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_ready", 64'(bus.Ready), 1);
    check("reset_out", 64'(bus.Out), 0);
    check("reset_valid", 64'(bus.OutValid), 0);
    check("reset_done", 64'(bus.Done), 0);
    nReset = 1'b1;

    spec_l    = '0;
    spec_l[5] = N1'(29389123);
    spec_l[4] = '1;
    spec_l[3] = N1'(231);
    spec_l[2] = N1'(281267);
    spec_l[1] = '1;
    spec_l[0] = N1'(6432);

    idle(10);
    send_frame(spec_l, -1, 0, -1, 1'b0, -1);
    idle(3);
    send_frame(spec_l, 50, 20, -1, 1'b0, -1);
    send_frame(spec_l, -1, 0, 10, 1'b0, -1);
    send_frame(~spec_l, -1, 0, -1, 1'b1, -1);
    idle(10);
    send_frame(spec_l, -1, 0, -1, 1'b0, 40);
    idle(20);
    send_frame(spec_l, NB - 1, 3, 0, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      send_frame(rand_lanes(),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB - 1)) : -1,
                 int'($urandom_range(1, 6)),
                 int'($urandom_range(0, NB - 1)),
                 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
    end
    idle(5);
    check("final_bits_drained", 64'(exp_q.size()), 0);
    check("final_done_drained", 64'(done_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
